cook_sequencer: RTL and testbench
=================================

# cook_sequencer

Top-level cooking controller for the microwave. It collects keypad digits into a three-digit M:SS preset, loads the preset into the countdown timer, and gates the 1 Hz tick into that timer. It also drives the magnetron enable from start, stop, clear and door events, and flags completion. It sits between the keypad encoder and the timer/magnetron, and replaces ad-hoc glue logic with one registered FSM.

## Interface
Parameters:
- BEEP_TICKS, default 3: number of tick_1hz pulses the done beeper stays on (used only with COOK_BEEP_EN).

Ports:
- clk  in  1  system clock.
- clrn  in  1  reset; asynchronous, active-low.
- tick_1hz  in  1  one-cycle pulse per second, synchronous to clk.
- digit_valid  in  1  one-cycle strobe; digit is valid.
- digit  in  4  BCD key value.
- start, stop, clear  in  1 each  one-cycle synchronous command pulses, active-high.
- door_closed  in  1  level; 1 = door shut.
- timer_zero  in  1  timer reports 0:00.
- ld_min, ld_tens, ld_ones  out  4 each  preset digits presented to the timer.
- load  out  1  one-cycle timer load strobe.
- count_en  out  1  timer decrement enable.
- mag_on  out  1  magnetron enable, registered.
- entry_err  out  1  one-cycle pulse when start is rejected for an invalid preset.
- done  out  1  level; cook cycle finished.
- beep  out  1  done beeper.

## Operation
- States: IDLE, ENTRY, LOAD, COOK, PAUSE, DONE.
- Preset buffer: min, tens and ones, each 4 bits. An accepted digit shifts left: tens→min, ones→tens, digit→ones. ld_* always reflect the buffer.
- A digit is accepted only in IDLE, ENTRY or DONE, and only when digit ≤ 9 and fewer than 3 digits have been entered. Otherwise it is ignored.
- If a digit arrives in DONE, the buffer is cleared first and the digit then enters as the first digit. The state moves to ENTRY.
- Event priority, evaluated every cycle: clear > door open > stop > start > timer_zero > digit.
- clear in any state → IDLE. The buffer and digit count go to 0, and mag_on, done and beep go to 0.
- ENTRY + start:
  - Door open or buffer = 0:00 → ignored.
  - tens > 5 → entry_err pulse; stay in ENTRY.
  - Otherwise → LOAD.
- LOAD lasts exactly one cycle with load = 1, then goes to COOK.
- COOK:
  - Door open → PAUSE.
  - stop → PAUSE.
  - timer_zero = 1 → DONE.
- PAUSE:
  - start with the door closed → COOK. This resumes without a reload.
  - stop → IDLE with the buffer cleared.
- DONE:
  - done = 1.
  - start → LOAD, re-cooking the same preset. The buffer is retained.
- count_en = tick_1hz AND (state == COOK). It is combinational and is never asserted in LOAD, PAUSE or DONE.
- mag_on = 1 exactly when the registered state is COOK.

## Timing
- Reset values: state IDLE, buffer 0, digit count 0. All outputs are 0: load, count_en, mag_on, entry_err, done, beep, and ld_* = 0.
- start accepted at edge N → load high for the cycle after edge N. At edge N+1 → COOK, and mag_on goes high after edge N+1.
- timer_zero is sampled only in COOK. LOAD isolates the stale zero flag from before the load.
- Door open sampled at edge N → mag_on low after edge N. Latency is 1 cycle.
- stop and start arriving in the same cycle → stop wins.
- A digit arriving in the same cycle as clear is discarded.
- entry_err is high for exactly 1 cycle per rejected start.
- Asynchronous clrn mid-cook → mag_on drops immediately, with no clock needed.

## Configuration
- COOK_BEEP_EN defined:
  - On entry to DONE, beep = 1.
  - beep stays high for BEEP_TICKS tick_1hz pulses, counted with a 4-bit counter, then falls. done stays high.
  - clear, start or a digit terminates beep immediately.
- COOK_BEEP_EN undefined:
  - beep is tied to 0 and the counter is not built.
  - DONE behaviour is otherwise identical.

## Test plan
- Keys 1, 3, 0, then start with the door closed → ld_* = 1/3/0. load pulses 1 cycle, then mag_on = 1. count_en follows each tick. timer_zero → done = 1, mag_on = 0.
- Keys 9, 9, then start → tens = 9 > 5 gives one entry_err pulse. State stays ENTRY and mag_on stays 0.
- Cooking, then door_closed = 0 → mag_on = 0 the next cycle and count_en = 0. Close the door, then start → mag_on = 1 with no load pulse.
- Cooking, then stop → PAUSE. A second stop → IDLE and ld_* = 0/0/0. A simultaneous start + stop in COOK → PAUSE.
- Keys 1, 2, 3, 4 → the fourth key is ignored and ld_* = 1/2/3. A digit of 0xA is ignored. Start with the door open → no load.
- With COOK_BEEP_EN and BEEP_TICKS = 3: reach DONE → beep high for 3 ticks then low, done stays 1. With the macro undefined → beep stays 0. Asserting clrn low mid-COOK → all outputs 0 asynchronously.

Source files
------------

// File: rtl/cook_sequencer.sv
// Microwave cook controller: keypad preset entry, timer load/gating, magnetron enable, done flag.
// Optional done beeper is built only when COOK_BEEP_EN is defined.
module cook_sequencer #(
  parameter int BEEP_TICKS = 3
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       tick_1hz,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       door_closed,
  input  logic       timer_zero,
  output logic [3:0] ld_min,
  output logic [3:0] ld_tens,
  output logic [3:0] ld_ones,
  output logic       load,
  output logic       count_en,
  output logic       mag_on,
  output logic       entry_err,
  output logic       done,
  output logic       beep
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    LOAD  = 3'd2,
    COOK  = 3'd3,
    PAUSE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] min_q, min_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic [1:0] cnt_q, cnt_d;
  logic       mag_on_q, mag_on_d;
  logic       done_q, done_d;
  logic       entry_err_q, entry_err_d;
  logic       digit_ok;
  logic       buf_zero;

  // In DONE the buffer is wiped before the digit lands, so the count limit does not apply.
  assign digit_ok = digit_valid && (digit <= 4'd9) && ((state_q == DONE) || (cnt_q < 2'd3));
  assign buf_zero = ({min_q, tens_q, ones_q} == 12'd0);

  always_comb begin
    state_d     = state_q;
    min_d       = min_q;
    tens_d      = tens_q;
    ones_d      = ones_q;
    cnt_d       = cnt_q;
    entry_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (digit_ok) begin
          min_d   = tens_q;
          tens_d  = ones_q;
          ones_d  = digit;
          cnt_d   = cnt_q + 2'd1;
          state_d = ENTRY;
        end
      end
      ENTRY: begin
        if (start) begin
          if (door_closed && !buf_zero) begin
            if (tens_q > 4'd5) entry_err_d = 1'b1;
            else               state_d     = LOAD;
          end
        end else if (digit_ok) begin
          min_d  = tens_q;
          tens_d = ones_q;
          ones_d = digit;
          cnt_d  = cnt_q + 2'd1;
        end
      end
      LOAD: begin
        state_d = COOK;
      end
      COOK: begin
        if (!door_closed || stop) state_d = PAUSE;
        else if (timer_zero)      state_d = DONE;
      end
      PAUSE: begin
        if (stop) begin
          state_d = IDLE;
          min_d   = 4'd0;
          tens_d  = 4'd0;
          ones_d  = 4'd0;
          cnt_d   = 2'd0;
        end else if (start && door_closed) begin
          state_d = COOK;
        end
      end
      DONE: begin
        if (start && door_closed) begin
          state_d = LOAD;
        end else if (digit_ok) begin
          min_d   = 4'd0;
          tens_d  = 4'd0;
          ones_d  = digit;
          cnt_d   = 2'd1;
          state_d = ENTRY;
        end
      end
      default: state_d = IDLE;
    endcase

    // clear outranks every other event, including a same-cycle digit.
    if (clear) begin
      state_d     = IDLE;
      min_d       = 4'd0;
      tens_d      = 4'd0;
      ones_d      = 4'd0;
      cnt_d       = 2'd0;
      entry_err_d = 1'b0;
    end
  end

  assign mag_on_d = (state_d == COOK);
  assign done_d   = (state_d == DONE);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= IDLE;
      min_q       <= 4'd0;
      tens_q      <= 4'd0;
      ones_q      <= 4'd0;
      cnt_q       <= 2'd0;
      mag_on_q    <= 1'b0;
      done_q      <= 1'b0;
      entry_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      min_q       <= min_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      cnt_q       <= cnt_d;
      mag_on_q    <= mag_on_d;
      done_q      <= done_d;
      entry_err_q <= entry_err_d;
    end
  end

  assign ld_min    = min_q;
  assign ld_tens   = tens_q;
  assign ld_ones   = ones_q;
  assign load      = (state_q == LOAD);
  assign count_en  = tick_1hz && (state_q == COOK);
  assign mag_on    = mag_on_q;
  assign done      = done_q;
  assign entry_err = entry_err_q;

`ifdef COOK_BEEP_EN
  localparam logic [3:0] BEEP_LIMIT = 4'(BEEP_TICKS);

  logic       beep_q, beep_d;
  logic [3:0] beep_cnt_q, beep_cnt_d;

  always_comb begin
    beep_d     = beep_q;
    beep_cnt_d = beep_cnt_q;
    if (clear || (state_d != DONE)) begin
      beep_d = 1'b0;
    end else if (state_q != DONE) begin
      beep_d     = 1'b1;
      beep_cnt_d = 4'd0;
    end else if (digit_valid || start) begin
      beep_d = 1'b0;
    end else if (beep_q && tick_1hz) begin
      beep_cnt_d = beep_cnt_q + 4'd1;
      if ((beep_cnt_q + 4'd1) >= BEEP_LIMIT) beep_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      beep_q     <= 1'b0;
      beep_cnt_q <= 4'd0;
    end else begin
      beep_q     <= beep_d;
      beep_cnt_q <= beep_cnt_d;
    end
  end

  assign beep = beep_q;
`else
  logic unused_beep_cfg;
  assign unused_beep_cfg = (BEEP_TICKS == 0);
  assign beep = 1'b0;
`endif

endmodule

// File: tb/tb_cook_sequencer.sv
// Directed bench for cook_sequencer; expected values are hand-derived per step.
module tb_cook_sequencer;

  logic       clk;
  logic       clrn;
  logic       tick_1hz;
  logic       digit_valid;
  logic [3:0] digit;
  logic       start, stop, clear;
  logic       door_closed;
  logic       timer_zero;
  logic [3:0] ld_min, ld_tens, ld_ones;
  logic       load, count_en, mag_on, entry_err, done, beep;

  int passes = 0;
  int total  = 0;

`ifdef COOK_BEEP_EN
  localparam logic BEEP_ON = 1'b1;
`else
  localparam logic BEEP_ON = 1'b0;
`endif

  cook_sequencer #(.BEEP_TICKS(3)) dut (
    .clk(clk), .clrn(clrn), .tick_1hz(tick_1hz),
    .digit_valid(digit_valid), .digit(digit),
    .start(start), .stop(stop), .clear(clear),
    .door_closed(door_closed), .timer_zero(timer_zero),
    .ld_min(ld_min), .ld_tens(ld_tens), .ld_ones(ld_ones),
    .load(load), .count_en(count_en), .mag_on(mag_on),
    .entry_err(entry_err), .done(done), .beep(beep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    digit = d;
    digit_valid = 1'b1;
    step();
    digit_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_tick();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    clrn = 1'b0; tick_1hz = 1'b0; digit_valid = 1'b0; digit = 4'd0;
    start = 1'b0; stop = 1'b0; clear = 1'b0; door_closed = 1'b1; timer_zero = 1'b0;
    #1;
    chk("rst_mag_async", {11'd0, mag_on}, 12'd0);
    step(); step();
    clrn = 1'b1;
    step();
    chk("rst_ld", {ld_min, ld_tens, ld_ones}, 12'h000);
    chk("rst_load", {11'd0, load}, 12'd0);
    chk("rst_mag", {11'd0, mag_on}, 12'd0);
    chk("rst_err", {11'd0, entry_err}, 12'd0);
    chk("rst_done", {11'd0, done}, 12'd0);
    chk("rst_beep", {11'd0, beep}, 12'd0);
    tick_1hz = 1'b1; #1;
    chk("rst_count_en", {11'd0, count_en}, 12'd0);
    tick_1hz = 1'b0;

    // Basic cook 1:30
    key(4'd1); key(4'd3); key(4'd0);
    chk("a_ld", {ld_min, ld_tens, ld_ones}, 12'h130);
    pulse_start();
    chk("a_load_hi", {11'd0, load}, 12'd1);
    chk("a_mag_lo_in_load", {11'd0, mag_on}, 12'd0);
    step();
    chk("a_load_lo", {11'd0, load}, 12'd0);
    chk("a_mag_hi", {11'd0, mag_on}, 12'd1);
    tick_1hz = 1'b1; #1;
    chk("a_count_en_tick", {11'd0, count_en}, 12'd1);
    step(); tick_1hz = 1'b0; #1;
    chk("a_count_en_idle", {11'd0, count_en}, 12'd0);
    timer_zero = 1'b1;
    step();
    timer_zero = 1'b0;
    chk("a_done", {11'd0, done}, 12'd1);
    chk("a_mag_off", {11'd0, mag_on}, 12'd0);
    chk("a_beep_entry", {11'd0, beep}, {11'd0, BEEP_ON});
    tick_1hz = 1'b1; #1;
    chk("a_count_en_done", {11'd0, count_en}, 12'd0);
    step(); tick_1hz = 1'b0;
    chk("a_beep_t1", {11'd0, beep}, {11'd0, BEEP_ON});
    pulse_tick();
    chk("a_beep_t2", {11'd0, beep}, {11'd0, BEEP_ON});
    pulse_tick();
    chk("a_beep_t3", {11'd0, beep}, 12'd0);
    chk("a_done_hold", {11'd0, done}, 12'd1);

    // Invalid preset 0:99
    pulse_clear();
    chk("b_clear_done", {11'd0, done}, 12'd0);
    chk("b_clear_ld", {ld_min, ld_tens, ld_ones}, 12'h000);
    key(4'd9); key(4'd9);
    pulse_start();
    chk("b_err_hi", {11'd0, entry_err}, 12'd1);
    chk("b_no_load", {11'd0, load}, 12'd0);
    step();
    chk("b_err_lo", {11'd0, entry_err}, 12'd0);
    chk("b_mag_lo", {11'd0, mag_on}, 12'd0);
    chk("b_ld", {ld_min, ld_tens, ld_ones}, 12'h099);

    // Digit limit and invalid key
    pulse_clear();
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    chk("c_fourth_ignored", {ld_min, ld_tens, ld_ones}, 12'h123);
    pulse_clear();
    key(4'd5); key(4'hA);
    chk("c_hex_ignored", {ld_min, ld_tens, ld_ones}, 12'h005);
    key(4'd2); key(4'd0);
    chk("c_ld_520", {ld_min, ld_tens, ld_ones}, 12'h520);
    door_closed = 1'b0;
    pulse_start();
    chk("c_door_open_no_load", {11'd0, load}, 12'd0);
    step();
    chk("c_door_open_no_mag", {11'd0, mag_on}, 12'd0);
    door_closed = 1'b1;

    // Door opened mid-cook, resume without reload
    pulse_start(); step();
    chk("d_cooking", {11'd0, mag_on}, 12'd1);
    door_closed = 1'b0;
    step();
    chk("d_door_mag_off", {11'd0, mag_on}, 12'd0);
    tick_1hz = 1'b1; #1;
    chk("d_pause_count_en", {11'd0, count_en}, 12'd0);
    tick_1hz = 1'b0;
    door_closed = 1'b1;
    pulse_start();
    chk("d_resume_no_load", {11'd0, load}, 12'd0);
    chk("d_resume_mag", {11'd0, mag_on}, 12'd1);

    // stop -> PAUSE, stop again -> IDLE with buffer cleared
    stop = 1'b1; step(); stop = 1'b0;
    chk("e_stop_pause", {11'd0, mag_on}, 12'd0);
    chk("e_buf_kept", {ld_min, ld_tens, ld_ones}, 12'h520);
    stop = 1'b1; step(); stop = 1'b0;
    chk("e_stop_idle_ld", {ld_min, ld_tens, ld_ones}, 12'h000);

    // start + stop together in COOK: stop wins
    key(4'd1); key(4'd0); key(4'd0);
    pulse_start(); step();
    chk("f_cook", {11'd0, mag_on}, 12'd1);
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    chk("f_stop_wins", {11'd0, mag_on}, 12'd0);
    chk("f_no_load", {11'd0, load}, 12'd0);
    pulse_start();
    chk("f_resume", {11'd0, mag_on}, 12'd1);

    // Stale timer_zero is masked by LOAD on a re-cook from DONE
    timer_zero = 1'b1;
    step();
    chk("g_done", {11'd0, done}, 12'd1);
    pulse_start();
    chk("g_reload", {11'd0, load}, 12'd1);
    chk("g_done_cleared", {11'd0, done}, 12'd0);
    step();
    chk("g_cook_despite_zero", {11'd0, mag_on}, 12'd1);
    step();
    timer_zero = 1'b0;
    chk("g_done_again", {11'd0, done}, 12'd1);
    chk("g_buf_retained", {ld_min, ld_tens, ld_ones}, 12'h100);

    // Digit in DONE restarts entry
    key(4'd7);
    chk("h_done_digit_ld", {ld_min, ld_tens, ld_ones}, 12'h007);
    chk("h_done_cleared", {11'd0, done}, 12'd0);
    chk("h_beep_off", {11'd0, beep}, 12'd0);

    // Digit alongside clear is discarded
    clear = 1'b1; digit = 4'd3; digit_valid = 1'b1;
    step();
    clear = 1'b0; digit_valid = 1'b0;
    chk("i_clear_digit", {ld_min, ld_tens, ld_ones}, 12'h000);

    // Asynchronous reset mid-cook
    key(4'd1); key(4'd0); key(4'd0);
    pulse_start(); step();
    chk("j_cook", {11'd0, mag_on}, 12'd1);
    tick_1hz = 1'b1;
    #2 clrn = 1'b0;
    #1;
    chk("j_async_mag", {11'd0, mag_on}, 12'd0);
    chk("j_async_count_en", {11'd0, count_en}, 12'd0);
    chk("j_async_ld", {ld_min, ld_tens, ld_ones}, 12'h000);
    chk("j_async_done", {11'd0, done}, 12'd0);
    tick_1hz = 1'b0;
    step();
    clrn = 1'b1;
    step();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
